// File: rtl/square_synth_pkg.sv
// Shared constants for the square-wave tone generator and its bench.
package square_synth_pkg;
  localparam int PERIOD_WIDTH_DEFAULT = 16;
endpackage

// File: rtl/square_synth_if.sv
// Control and audio signals of the square-wave generator; the bench drives the
// master side and the core sits on the slave side.
interface square_synth_if
  import square_synth_pkg::*;
#(
  parameter int PW = PERIOD_WIDTH_DEFAULT
);
  logic [PW-1:0] HALF_PERIOD;
  logic          ENABLE;
  logic          SAMPLE_TRIGGER;
  logic          AUDIO;

  modport master (
    output HALF_PERIOD,
    output ENABLE,
    output SAMPLE_TRIGGER,
    input  AUDIO
  );

  modport slave (
    input  HALF_PERIOD,
    input  ENABLE,
    input  SAMPLE_TRIGGER,
    output AUDIO
  );
endinterface

// File: rtl/square_synth_tick_counter.sv
// Counts sample ticks within one half-period and pulses TERM on the tick that
// completes it; the counter never wraps.
module square_synth_tick_counter #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CLEAR,
  input  logic             TICK,
  input  logic [WIDTH-1:0] LIMIT,
  output logic             TERM
);
  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    // cnt >= LIMIT-1 evaluated one bit wider so a shrunk LIMIT never underflows
    TERM  = TICK && !CLEAR &&
            (({1'b0, cnt_q} + (WIDTH+1)'(1)) >= {1'b0, LIMIT});
    cnt_d = cnt_q;
    if (CLEAR) begin
      cnt_d = '0;
    end else if (TERM) begin
      cnt_d = '0;
    end else if (TICK) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/square_synth_core.sv
// Square-wave tone generator toggling AUDIO every HALF_PERIOD sample ticks.
// Define SQUARE_SYNTH_PERIOD_LATCH_EN to apply HALF_PERIOD changes only at half-period boundaries.
module square_synth_core
  import square_synth_pkg::*;
#(
  parameter int PERIOD_WIDTH = PERIOD_WIDTH_DEFAULT
) (
  input  logic          CLK,
  input  logic          RESET,
  square_synth_if.slave bus
);
  logic [PERIOD_WIDTH-1:0] p_eff;
  logic                    active;
  logic                    term;
  logic                    audio_q, audio_d;

`ifdef SQUARE_SYNTH_PERIOD_LATCH_EN
  logic [PERIOD_WIDTH-1:0] period_q, period_d;
  logic                    running_q, running_d;

  // The live input is used only on the first active cycle, before the latch holds it.
  always_comb begin
    p_eff     = running_q ? period_q : bus.HALF_PERIOD;
    active    = bus.ENABLE && (p_eff != '0);
    running_d = active;
  end

  always_comb begin
    period_d = period_q;
    if (active && (!running_q || term)) begin
      period_d = bus.HALF_PERIOD;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      period_q  <= '0;
      running_q <= 1'b0;
    end else begin
      period_q  <= period_d;
      running_q <= running_d;
    end
  end
`else
  always_comb begin
    p_eff  = bus.HALF_PERIOD;
    active = bus.ENABLE && (p_eff != '0);
  end
`endif

  square_synth_tick_counter #(
    .WIDTH (PERIOD_WIDTH)
  ) u_tick_counter (
    .CLK   (CLK),
    .RESET (RESET),
    .CLEAR (!active),
    .TICK  (bus.SAMPLE_TRIGGER),
    .LIMIT (p_eff),
    .TERM  (term)
  );

  // Inactive forces silence, so a fresh enable always starts from a low level.
  always_comb begin
    audio_d = audio_q;
    if (!active) begin
      audio_d = 1'b0;
    end else if (term) begin
      audio_d = ~audio_q;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      audio_q <= 1'b0;
    end else begin
      audio_q <= audio_d;
    end
  end

  assign bus.AUDIO = audio_q;
endmodule

// File: tb/tb_square_synth_core.sv
// Randomized and directed bench for square_synth_core against a tick-counting tone model.
module tb_square_synth_core;
  import square_synth_pkg::*;

  localparam int PW = PERIOD_WIDTH_DEFAULT;

  logic CLK = 1'b0;
  logic RESET;
  int   n_checks = 0;
  int   n_pass   = 0;

  square_synth_if #(.PW(PW)) bus ();

  square_synth_core #(.PERIOD_WIDTH(PW)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: a half lasts P ticks; elapsed counts ticks in the current half.
  int m_elapsed;
  int m_p;
  int m_cur_p;
  bit m_run;
  bit m_audio;

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      m_elapsed = 0; m_p = 0; m_run = 0; m_audio = 0;
    end else begin
`ifdef SQUARE_SYNTH_PERIOD_LATCH_EN
      m_cur_p = m_run ? m_p : int'(bus.HALF_PERIOD);
`else
      m_cur_p = int'(bus.HALF_PERIOD);
`endif
      if (!bus.ENABLE || m_cur_p == 0) begin
        m_elapsed = 0; m_audio = 0; m_run = 0;
      end else begin
        if (!m_run) m_p = int'(bus.HALF_PERIOD);
        m_run = 1;
        if (bus.SAMPLE_TRIGGER) begin
          m_elapsed++;
          if (m_elapsed >= m_cur_p) begin
            m_audio = ~m_audio;
            m_elapsed = 0;
            m_p = int'(bus.HALF_PERIOD);
          end
        end
      end
    end
  end

  always @(negedge CLK) check("audio_vs_model", longint'(bus.AUDIO), longint'(m_audio));

  task automatic step(input bit trig);
    bus.SAMPLE_TRIGGER = trig;
    @(posedge CLK); #1;
    bus.SAMPLE_TRIGGER = 1'b0;
  endtask

  task automatic ticks_until_change(input int max, output int n);
    logic start;
    start = bus.AUDIO;
    n = 0;
    while (n < max) begin
      step(1'b1);
      n++;
      if (bus.AUDIO !== start) return;
    end
    n = -1;
  endtask

  task automatic fresh_enable(input int hp);
    bus.ENABLE = 1'b0;
    step(1'b0);
    bus.HALF_PERIOD = PW'(hp);
    bus.ENABLE = 1'b1;
  endtask

  int n, prev, first, ntog, changes;
  logic last;

  initial begin
    RESET = 1'b1;
    bus.ENABLE = 1'b1;
    bus.HALF_PERIOD = PW'(3);
    bus.SAMPLE_TRIGGER = 1'b0;
    #1;
    check("reset_audio", longint'(bus.AUDIO), 0);
    @(posedge CLK); #1;
    check("reset_audio_clocked", longint'(bus.AUDIO), 0);
    RESET = 1'b0;

    // First rise on the 3rd tick after reset release, then async silence mid-tone.
    ticks_until_change(10, n);
    check("reset_first_rise_ticks", n, 3);
    check("reset_rise_level", longint'(bus.AUDIO), 1);
    #2 RESET = 1'b1;
    #1 check("async_reset_mid_tone", longint'(bus.AUDIO), 0);
    @(posedge CLK); #1;
    RESET = 1'b0;

    // Steady tone: HALF_PERIOD=4, tick every 128 clocks.
    fresh_enable(4);
    prev = -1; first = -1; ntog = 0; last = bus.AUDIO;
    for (int c = 0; c < 2000; c++) begin
      step(c % 128 == 0);
      if (bus.AUDIO !== last) begin
        last = bus.AUDIO;
        check("tone_toggle_after_tick", c % 128, 0);
        if (prev >= 0) check("tone_interval", c - prev, 512);
        else first = c;
        prev = c;
        ntog++;
      end
    end
    check("tone_first_rise_clock", first, 384);
    check("tone_toggle_count", ntog, 4);

    // Silence: zero period while enabled, then disabled with a nonzero period.
    fresh_enable(0);
    changes = 0;
    for (int i = 0; i < 20; i++) begin step(1'b1); if (bus.AUDIO !== 1'b0) changes++; end
    check("silence_hp0", changes, 0);
    bus.HALF_PERIOD = PW'(5);
    bus.ENABLE = 1'b0;
    changes = 0;
    for (int i = 0; i < 20; i++) begin step(1'b1); if (bus.AUDIO !== 1'b0) changes++; end
    check("silence_disabled", changes, 0);

    // Period shrink from 10 to 3 with 7 ticks already counted.
    fresh_enable(10);
    step(1'b0);
    for (int i = 0; i < 7; i++) step(1'b1);
    check("shrink_no_toggle_yet", longint'(bus.AUDIO), 0);
    bus.HALF_PERIOD = PW'(3);
    ticks_until_change(20, n);
`ifdef SQUARE_SYNTH_PERIOD_LATCH_EN
    check("shrink_ticks_to_toggle", n, 3);
`else
    check("shrink_ticks_to_toggle", n, 1);
`endif
    ticks_until_change(20, n);
    check("shrink_next_half", n, 3);

    // Disable on a terminal tick wins; re-enable with period 2.
    fresh_enable(2);
    step(1'b1);
    bus.ENABLE = 1'b0;
    step(1'b1);
    check("collision_audio", longint'(bus.AUDIO), 0);
    bus.HALF_PERIOD = PW'(2);
    bus.ENABLE = 1'b1;
    ticks_until_change(10, n);
    check("reenable_first_rise", n, 2);

    // Period 1 toggles on every tick.
    fresh_enable(1);
    for (int i = 0; i < 8; i++) begin
      step(1'b1);
      check("hp1_level", longint'(bus.AUDIO), longint'((i + 1) % 2));
    end

    // Maximum period: first toggle on tick 65535.
    fresh_enable(16'hFFFF);
    ticks_until_change(70000, n);
    check("hpmax_first_toggle", n, 65535);

    // Randomized traffic checked by the per-cycle compare.
    fresh_enable(3);
    for (int c = 0; c < 4000; c++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 3) bus.ENABLE = ~bus.ENABLE;
      else if (r < 8) bus.HALF_PERIOD = PW'($urandom_range(0, 6));
      if (r == 99) begin
        RESET = 1'b1;
        step(1'b0);
        RESET = 1'b0;
      end
      step($urandom_range(0, 2) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
